// File: rtl/prime_recover_pkg.sv
// Shared types and width constants for the prime_recover block and its
// serial square-root helper. SIZE is the bit width of one prime factor.
package prime_recover_pkg;

  localparam int SIZE   = 12;
  localparam int ROOT_W = SIZE;          // d, p, q
  localparam int SUM_W  = SIZE + 1;      // s = p + q
  localparam int SQ_W   = 2 * SIZE + 2;  // s*s and 4n before truncation
  localparam int MOD_W  = 2 * SIZE;      // n, phi, D

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ROOT,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/prime_recover_if.sv
// Request/result bundle between the (modulus, totient) source and
// prime_recover. The source side is master, the recovery block is slave.
interface prime_recover_if;

  logic                                enabled;
  logic [prime_recover_pkg::MOD_W-1:0]  modulus;
  logic [prime_recover_pkg::MOD_W-1:0]  totient;
  logic [prime_recover_pkg::ROOT_W-1:0] p;
  logic [prime_recover_pkg::ROOT_W-1:0] q;
  logic                                error;
  logic                                finished;

  modport master (
    output enabled, modulus, totient,
    input  p, q, error, finished
  );

  modport slave (
    input  enabled, modulus, totient,
    output p, q, error, finished
  );

endinterface

// File: rtl/prime_recover_isqrt_serial.sv
// Restoring integer square root, one root bit per clock, MSB first.
// start loads the radicand; ROOT_W iterations follow. last is high during
// the final iteration so a caller can leave its wait state on that edge and
// read root on the following cycle.
module isqrt_serial
  import prime_recover_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MOD_W-1:0]  radicand,
  output logic              last,
  output logic [ROOT_W-1:0] root
);

  localparam int REM_W = ROOT_W + 2;
  localparam int TMP_W = ROOT_W + 4;
  localparam int CNT_W = $clog2(ROOT_W);

  logic [MOD_W-1:0] rad_q;
  logic [REM_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [TMP_W-1:0] rem_sh;
  logic [TMP_W-1:0] trial;
  logic             fits;

  // Bring down the next radicand bit pair and form the trial subtrahend 4r+1.
  always_comb begin
    rem_sh = {rem_q, rad_q[MOD_W-1 -: 2]};
    trial  = {2'b00, root, 2'b01};
    fits   = (rem_sh >= trial);
  end

  assign last = busy_q && (cnt_q == '0);

  // Iteration registers; the bit counter runs down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rad_q  <= radicand;
      rem_q  <= '0;
      root   <= '0;
      cnt_q  <= CNT_W'(ROOT_W - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rad_q <= rad_q << 2;
      if (fits) begin
        rem_q <= REM_W'(rem_sh - trial);
        root  <= {root[ROOT_W-2:0], 1'b1};
      end else begin
        rem_q <= REM_W'(rem_sh);
        root  <= {root[ROOT_W-2:0], 1'b0};
      end
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/prime_recover.sv
// Recovers the two prime factors of an RSA modulus from (n, phi):
//   s = n - phi + 1 = p + q,  D = s*s - 4n = (p - q)^2,  d = isqrt(D),
//   p = (s + d) / 2,  q = (s - d) / 2.
// Optional build macro PRIME_RECOVER_CHECK_EN adds a final p*q == n test.
//
//   state | meaning
//   IDLE  | waiting for enabled; captures n and phi
//   PREP  | forms s and D, rejects impossible pairs early
//   ROOT  | serial square root of D, SIZE cycles
//   CHECK | verifies d*d == D and parity, forms p and q
//   DONE  | finished high until enabled drops
module prime_recover
  import prime_recover_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  prime_recover_if.slave   bus
);

  state_t             state_q, state_d;
  logic [MOD_W-1:0]   n_q, phi_q, d_q;
  logic               err_pend;
  logic [ROOT_W-1:0]  p_q, q_q;
  logic               err_q;

  logic [SUM_W-1:0]   s;
  logic [SQ_W-1:0]    s_sq, four_n, d_full;
  logic               early_err, d_trunc_err;
  logic [ROOT_W-1:0]  root;
  logic               root_last, root_start;
  logic [MOD_W-1:0]   root_sq;
  logic [SUM_W:0]     sum_sd;
  logic [SUM_W-1:0]   p_full;
  logic [ROOT_W-1:0]  q_full;
  logic               check_err;

  // Sum of factors and discriminant from the captured operands.
  always_comb begin
    s           = SUM_W'(n_q) - SUM_W'(phi_q) + SUM_W'(1);
    s_sq        = SQ_W'(s) * SQ_W'(s);
    four_n      = {n_q, 2'b00};
    early_err   = (phi_q > n_q) || (s == '0) || (s_sq < four_n);
    d_full      = s_sq - four_n;
    d_trunc_err = |d_full[SQ_W-1:MOD_W];
  end

  // Factor formation and consistency tests on the finished root.
  always_comb begin
    root_sq   = MOD_W'(root) * MOD_W'(root);
    sum_sd    = (SUM_W+1)'(s) + (SUM_W+1)'(root);
    p_full    = SUM_W'(sum_sd >> 1);
    q_full    = ROOT_W'((s - SUM_W'(root)) >> 1);
    check_err = (root_sq != d_q) || sum_sd[0] || p_full[SUM_W-1];
`ifdef PRIME_RECOVER_CHECK_EN
    if ((MOD_W'(p_full[ROOT_W-1:0]) * MOD_W'(q_full)) != n_q) check_err = 1'b1;
`endif
  end

  isqrt_serial u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (root_start),
    .radicand (d_full[MOD_W-1:0]),
    .last     (root_last),
    .root     (root)
  );

  // Next-state decode and square-root launch.
  always_comb begin
    state_d    = state_q;
    root_start = 1'b0;
    case (state_q)
      IDLE:  if (bus.enabled) state_d = PREP;
      PREP: begin
        if (early_err) begin
          state_d = DONE;
        end else begin
          root_start = 1'b1;
          state_d    = ROOT;
        end
      end
      ROOT:  if (root_last) state_d = CHECK;
      CHECK: state_d = DONE;
      DONE:  if (!bus.enabled) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture and result registers; results only move when entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q      <= '0;
      phi_q    <= '0;
      d_q      <= '0;
      err_pend <= 1'b0;
      p_q      <= '0;
      q_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enabled) begin
            n_q      <= bus.modulus;
            phi_q    <= bus.totient;
            err_pend <= 1'b0;
          end
        end
        PREP: begin
          if (early_err) begin
            p_q   <= '0;
            q_q   <= '0;
            err_q <= 1'b1;
          end else begin
            d_q      <= d_full[MOD_W-1:0];
            err_pend <= d_trunc_err;
          end
        end
        CHECK: begin
          if (err_pend || check_err) begin
            p_q   <= '0;
            q_q   <= '0;
            err_q <= 1'b1;
          end else begin
            p_q   <= p_full[ROOT_W-1:0];
            q_q   <= q_full;
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.p        = p_q;
  assign bus.q        = q_q;
  assign bus.error    = err_q;
  assign bus.finished = (state_q == DONE);

endmodule
